camellia_subkey_gen: RTL and testbench

Sequential subkey generator for the 128-bit Camellia datapath. It sits directly downstream of the KA derivation stage: it latches KL and the derived KA and streams the 26 64-bit subkeys to the round/FL datapath, one per handshake, in usage order: kw1, kw2, k1–k18 with ke1–ke4 interleaved, then kw3, kw4. The stream is a valid/ready interface with an index tag, so the consumer can buffer the subkeys or apply them directly.

---
 rtl/camellia_subkey_gen.sv | 131 +++++++++++++
 tb/tb_camellia_subkey_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/camellia_subkey_gen.sv
// Camellia-128 subkey streamer: latches KL/KA and emits the 26 subkeys in usage
// order over a valid/ready interface, each tagged with its index.
module camellia_subkey_gen #(
  parameter int NUM_SK = 26
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] KL,
  input  logic [127:0] KA,
  output logic [63:0]  sk,
  output logic [4:0]   sk_idx,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | waiting for start, keys not latched
  // EMIT  | presenting subkey sk_idx, advancing on handshake
  // DONE  | one-cycle done pulse, start ignored
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_SK - 1);

  state_t        state;
  logic [127:0]  kl_q, ka_q;
  logic [4:0]    nidx;
  logic [63:0]   next_sk;

  logic [127:0] kl_r15, kl_r45, kl_r77, kl_r94, kl_r111;
  logic [127:0] ka_r15, ka_r30, ka_r60, ka_r94, ka_r111;
  logic [63:0]  kl_r60_lo, ka_r45_hi;

  // Fixed-wire rotations; only the halves actually consumed are formed
  assign kl_r15    = {kl_q[112:0], kl_q[127:113]};
  assign kl_r45    = {kl_q[82:0],  kl_q[127:83]};
  assign kl_r60_lo = {kl_q[3:0],   kl_q[127:68]};
  assign kl_r77    = {kl_q[50:0],  kl_q[127:51]};
  assign kl_r94    = {kl_q[33:0],  kl_q[127:34]};
  assign kl_r111   = {kl_q[16:0],  kl_q[127:17]};
  assign ka_r15    = {ka_q[112:0], ka_q[127:113]};
  assign ka_r30    = {ka_q[97:0],  ka_q[127:98]};
  assign ka_r45_hi = ka_q[82:19];
  assign ka_r60    = {ka_q[67:0],  ka_q[127:68]};
  assign ka_r94    = {ka_q[33:0],  ka_q[127:34]};
  assign ka_r111   = {ka_q[16:0],  ka_q[127:17]};

  assign nidx = sk_idx + 5'd1;

  always_comb begin
    next_sk = '0;
    case (nidx)
      5'd1:  next_sk = kl_q[63:0];
      5'd2:  next_sk = ka_q[127:64];
      5'd3:  next_sk = ka_q[63:0];
      5'd4:  next_sk = kl_r15[127:64];
      5'd5:  next_sk = kl_r15[63:0];
      5'd6:  next_sk = ka_r15[127:64];
      5'd7:  next_sk = ka_r15[63:0];
      5'd8:  next_sk = ka_r30[127:64];
      5'd9:  next_sk = ka_r30[63:0];
      5'd10: next_sk = kl_r45[127:64];
      5'd11: next_sk = kl_r45[63:0];
      5'd12: next_sk = ka_r45_hi;
      5'd13: next_sk = kl_r60_lo;
      5'd14: next_sk = ka_r60[127:64];
      5'd15: next_sk = ka_r60[63:0];
      5'd16: next_sk = kl_r77[127:64];
      5'd17: next_sk = kl_r77[63:0];
      5'd18: next_sk = kl_r94[127:64];
      5'd19: next_sk = kl_r94[63:0];
      5'd20: next_sk = ka_r94[127:64];
      5'd21: next_sk = ka_r94[63:0];
      5'd22: next_sk = kl_r111[127:64];
      5'd23: next_sk = kl_r111[63:0];
      5'd24: next_sk = ka_r111[127:64];
      5'd25: next_sk = ka_r111[63:0];
      default: next_sk = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      kl_q     <= '0;
      ka_q     <= '0;
      sk       <= '0;
      sk_idx   <= '0;
      sk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            kl_q     <= KL;
            ka_q     <= KA;
            // kw1 comes straight from the port so it is ready on the first EMIT cycle
            sk       <= KL[127:64];
            sk_idx   <= '0;
            sk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (sk_ready) begin
            if (sk_idx == LAST_IDX) begin
              sk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              sk_idx <= nidx;
              sk     <= next_sk;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camellia_subkey_gen.sv
// Scoreboard bench for camellia_subkey_gen: driver pushes model subkeys per run,
// a negedge monitor pops and compares on every handshake.
module tb_camellia_subkey_gen;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [127:0] KL = '0;
  logic [127:0] KA = '0;
  logic [63:0]  sk;
  logic [4:0]   sk_idx;
  logic         sk_valid;
  logic         sk_ready = 1'b1;
  logic         busy;
  logic         done;

  camellia_subkey_gen dut (
    .CLK(CLK), .RST(RST), .start(start), .KL(KL), .KA(KA),
    .sk(sk), .sk_idx(sk_idx), .sk_valid(sk_valid), .sk_ready(sk_ready),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] idx; logic [63:0] val; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;

  // Key schedule table: rotation amount and source key per index; even idx take L, odd take R
  localparam int ROT[26] = '{0,0,0,0,15,15,15,15,30,30,45,45,45,60,60,60,77,77,94,94,94,94,111,111,111,111};
  localparam bit USE_KA[26] = '{0,0,1,1,0,0,1,1,1,1,0,0,1,0,1,1,0,0,0,0,1,1,0,0,1,1};

  function automatic logic [63:0] model(input logic [127:0] kl, input logic [127:0] ka, input int i);
    logic [127:0] x, y;
    int r;
    x = USE_KA[i] ? ka : kl;
    r = ROT[i];
    y = (r == 0) ? x : ((x << r) | (x >> (128 - r)));
    return (i % 2 == 0) ? y[127:64] : y[63:0];
  endfunction

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor
  bit          stall_prev = 0;
  logic [63:0] stall_sk;
  logic [4:0]  stall_idx;
  bit          done_pending = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      stall_prev   = 0;
      done_pending = 0;
    end else begin
      if (done_pending) begin
        check(done && !sk_valid && !busy, "done_pulse", {done, sk_valid, busy}, 3'b100);
        done_pending = 0;
      end else if (done) begin
        check(0, "unexpected_done", done, 0);
      end
      if (sk_valid) begin
        if (!busy) check(0, "busy_in_emit", busy, 1);
        if (stall_prev)
          check(sk == stall_sk && sk_idx == stall_idx, "stall_stable", {sk_idx, sk}, {stall_idx, stall_sk});
        if (sk_ready) begin
          if (exp_q.size() == 0) begin
            check(0, "unexpected_subkey", {sk_idx, sk}, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(sk_idx == e.idx && sk == e.val, $sformatf("subkey_idx%0d", e.idx), {sk_idx, sk}, {e.idx, e.val});
            if (e.idx == 5'd25) done_pending = 1;
          end
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_sk   = sk;
          stall_idx  = sk_idx;
        end
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic begin_run(input logic [127:0] kl, input logic [127:0] ka);
    @(posedge CLK); #1;
    KL = kl; KA = ka; start = 1'b1;
    for (int i = 0; i < 26; i++) exp_q.push_back('{idx: 5'(i), val: model(kl, ka, i)});
    @(posedge CLK); #1;
    start = 1'b0;
    check(sk_valid && busy && sk_idx == 0 && sk == kl[127:64], "start_accept",
          {busy, sk_valid, sk_idx, sk}, {1'b1, 1'b1, 5'd0, kl[127:64]});
  endtask

  task automatic run_keys(input logic [127:0] kl, input logic [127:0] ka, input bit rand_ready, input bit poke);
    int budget;
    begin_run(kl, ka);
    budget = 0;
    while (!done && budget < 1000) begin
      sk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        KL = rand128();
        KA = rand128();
        start = ($urandom_range(0, 5) == 0);
      end
      @(posedge CLK); #1;
      budget++;
    end
    start = 1'b0;
    if (budget >= 1000) check(0, "run_timeout", budget, 0);
    check(exp_q.size() == 0, "run_drained", exp_q.size(), 0);
    // start during the DONE cycle must not launch a run
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check(!sk_valid && !busy, "start_in_done_ignored", {sk_valid, busy}, 2'b00);
  endtask

  task automatic abort_at_10();
    int budget;
    begin_run(rand128(), rand128());
    budget = 0;
    while (!(sk_valid && sk_idx == 5'd10) && budget < 1000) begin
      sk_ready = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      budget++;
    end
    if (budget >= 1000) check(0, "abort_timeout", budget, 0);
    RST = 1'b0;
    #1;
    check(!sk_valid && !busy && !done && sk == 0 && sk_idx == 0, "async_reset",
          {sk_valid, busy, done, sk_idx, sk}, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check(!sk_valid && !busy && !done, "idle_after_reset", {sk_valid, busy, done}, 0);
  endtask

  initial begin
    // Reset held with start high
    start = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check(!sk_valid && !busy && !done && sk == 0 && sk_idx == 0, "reset_state",
          {sk_valid, busy, done, sk_idx, sk}, 0);
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check(!sk_valid && !busy && !done && sk == 0 && sk_idx == 0, "idle_after_release",
          {sk_valid, busy, done, sk_idx, sk}, 0);

    run_keys(128'h1, 128'h0, 1'b0, 1'b0);
    run_keys(128'h0, 128'h1, 1'b0, 1'b0);
    // Known vector; KA (and KL) ports scrambled mid-run, extra starts poked
    run_keys(128'h0123456789ABCDEFFEDCBA9876543210, 128'h0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) run_keys(rand128(), rand128(), 1'b1, 1'b1);
    abort_at_10();
    run_keys(rand128(), rand128(), 1'b1, 1'b0);

    repeat (3) @(posedge CLK);
    #1;
    check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
